// File: rtl/vram_pkg.sv
// vram_pkg: VRAM geometry shared with the VGA and writer blocks,
// client index sizing and the read-return tag type.
package vram_pkg;

   localparam int VRAM_DATA_W = 640;
   localparam int VRAM_ADDR_W = 9;
   localparam int MAX_CLIENTS = 8;

   function automatic int client_idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int TAG_ID_W = client_idx_w(MAX_CLIENTS);

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: client side of the VRAM port-A arbiter,
// request/grant handshake plus tagged read return.
interface vram_arbiter_if import vram_pkg::*; #(
   parameter int NUM_CLIENTS = 2,
   parameter int DATA_W      = VRAM_DATA_W,
   parameter int ADDR_W      = VRAM_ADDR_W
) ();

   logic [NUM_CLIENTS-1:0]        cl_req;
   logic [NUM_CLIENTS-1:0]        cl_we;
   logic [NUM_CLIENTS-1:0]        cl_lock;
   logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr;
   logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata;
   logic [NUM_CLIENTS-1:0]        cl_gnt;
   logic [NUM_CLIENTS-1:0]        cl_rvalid;
   logic [DATA_W-1:0]             cl_rdata;

   modport master (
      output cl_req, cl_we, cl_lock, cl_addr, cl_wdata,
      input  cl_gnt, cl_rvalid, cl_rdata
   );

   modport slave (
      input  cl_req, cl_we, cl_lock, cl_addr, cl_wdata,
      output cl_gnt, cl_rvalid, cl_rdata
   );

endinterface

// File: rtl/vram_arbiter_rr_picker.sv
// rr_picker: one-hot round-robin select, first requester at or
// after ptr_i, wrapping at NUM_CLIENTS-1.
module rr_picker import vram_pkg::*; #(
   parameter int NUM_CLIENTS = 2
) (
   input  logic [NUM_CLIENTS-1:0]                    req_i,
   input  logic [client_idx_w(NUM_CLIENTS)-1:0]      ptr_i,
   output logic [NUM_CLIENTS-1:0]                    gnt_o,
   output logic [client_idx_w(NUM_CLIENTS)-1:0]      id_o,
   output logic                                      any_o
);

   localparam int IW = client_idx_w(NUM_CLIENTS);
   localparam int SW = IW + 1;

   logic [SW-1:0] sum;
   logic [IW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      any_o = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int off = 0; off < NUM_CLIENTS; off++) begin
         sum = {1'b0, ptr_i} + SW'(off);
         if (sum >= SW'(NUM_CLIENTS))
            sum = sum - SW'(NUM_CLIENTS);
         idx = sum[IW-1:0];
         if (!any_o && req_i[idx]) begin
            any_o      = 1'b1;
            gnt_o[idx] = 1'b1;
            id_o       = idx;
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin N-client arbiter onto VRAM port A with
// tagged read return; define VRAM_ARB_LOCK_EN for multi-line bus lock.
module vram_arbiter import vram_pkg::*; #(
   parameter int NUM_CLIENTS = 2,
   parameter int DATA_W      = VRAM_DATA_W,
   parameter int ADDR_W      = VRAM_ADDR_W,
   parameter int RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   vram_arbiter_if.slave     cl,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int IW = client_idx_w(NUM_CLIENTS);

   logic [IW-1:0]          p_q, p_d;
   logic [NUM_CLIENTS-1:0] pick_req, pick_gnt;
   logic [IW-1:0]          gnt_id;
   logic                   pick_any, gnt_any;
   logic                   mem_we_q;
   logic [ADDR_W-1:0]      mem_addr_q;
   logic [DATA_W-1:0]      mem_wdata_q;
   rd_tag_t                tag_q [RD_LATENCY];
   logic [NUM_CLIENTS-1:0] cl_rvalid_q;

`ifdef VRAM_ARB_LOCK_EN
   logic          own_vld_q;
   logic [IW-1:0] own_q;
   logic          own_hold;

   // Owner that still requests is the only visible requester.
   assign own_hold = own_vld_q & cl.cl_req[own_q];
   assign pick_req = own_hold ? (NUM_CLIENTS'(1) << own_q) : cl.cl_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_vld_q <= 1'b0;
         own_q     <= '0;
      end else if (gnt_any) begin
         own_vld_q <= cl.cl_lock[gnt_id];
         own_q     <= gnt_id;
      end else if (!own_hold) begin
         own_vld_q <= 1'b0;
      end
   end
`else
   assign pick_req = cl.cl_req;
`endif

   rr_picker #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
      .req_i (pick_req),
      .ptr_i (p_q),
      .gnt_o (pick_gnt),
      .id_o  (gnt_id),
      .any_o (pick_any)
   );

   assign gnt_any   = rst_n & pick_any;
   assign cl.cl_gnt = rst_n ? pick_gnt : '0;

   always_comb begin
      p_d = gnt_id + IW'(1);
      if (gnt_id == IW'(NUM_CLIENTS - 1))
         p_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cl_rvalid_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++)
            tag_q[i] <= '0;
      end else begin
         mem_we_q <= gnt_any & cl.cl_we[gnt_id];
         if (gnt_any) begin
            p_q        <= p_d;
            mem_addr_q <= cl.cl_addr[gnt_id*ADDR_W +: ADDR_W];
            if (cl.cl_we[gnt_id])
               mem_wdata_q <= cl.cl_wdata[gnt_id*DATA_W +: DATA_W];
         end
         tag_q[0].valid <= gnt_any & ~cl.cl_we[gnt_id];
         tag_q[0].id    <= TAG_ID_W'(gnt_id);
         for (int i = 1; i < RD_LATENCY; i++)
            tag_q[i] <= tag_q[i-1];
         // Tag pipe lines up with the VRAM output register.
         cl_rvalid_q <= tag_q[RD_LATENCY-1].valid
                        ? (NUM_CLIENTS'(1) << tag_q[RD_LATENCY-1].id)
                        : '0;
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cl.cl_rvalid = cl_rvalid_q;
   assign cl.cl_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench, two 3-client arbiters sharing
// stimulus, one at RD_LATENCY 1 and one at RD_LATENCY 3.
module tb_vram_arbiter;
   import vram_pkg::*;

   localparam int N  = 3;
   localparam int DW = 640;
   localparam int AW = 9;

   typedef struct {
      int            due;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      int            due;
      logic [N-1:0]  tag;
      logic [DW-1:0] d;
   } rd_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [N-1:0]  req, we, lock;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] wd   [N];

   logic          mwe_a, mwe_b;
   logic [AW-1:0] maddr_a, maddr_b;
   logic [DW-1:0] mwd_a, mwd_b, mrd_a, mrd_b;

   vram_arbiter_if #(.NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW)) ifa ();
   vram_arbiter_if #(.NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW)) ifb ();

   assign ifa.cl_req   = req;
   assign ifa.cl_we    = we;
   assign ifa.cl_lock  = lock;
   assign ifa.cl_addr  = {addr[2], addr[1], addr[0]};
   assign ifa.cl_wdata = {wd[2], wd[1], wd[0]};
   assign ifb.cl_req   = req;
   assign ifb.cl_we    = we;
   assign ifb.cl_lock  = lock;
   assign ifb.cl_addr  = {addr[2], addr[1], addr[0]};
   assign ifb.cl_wdata = {wd[2], wd[1], wd[0]};

   vram_arbiter #(
      .NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .cl(ifa),
      .mem_we(mwe_a), .mem_addr(maddr_a),
      .mem_wdata(mwd_a), .mem_rdata(mrd_a)
   );

   vram_arbiter #(
      .NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(3)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .cl(ifb),
      .mem_we(mwe_b), .mem_addr(maddr_b),
      .mem_wdata(mwd_b), .mem_rdata(mrd_b)
   );

   // VRAM port-A models: 1-cycle and 3-cycle registered read.
   logic [DW-1:0] mem_a [512];
   logic [DW-1:0] mem_b [512];
   logic [DW-1:0] pb    [3];

   always @(posedge clk) begin
      if (mwe_a) mem_a[maddr_a] <= mwd_a;
      mrd_a <= mem_a[maddr_a];
   end

   always @(posedge clk) begin
      if (mwe_b) mem_b[maddr_b] <= mwd_b;
      pb[0] <= mem_b[maddr_b];
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign mrd_b = pb[2];

   logic [N-1:0] gq  [$];
   wr_t          wq  [$];
   rd_t          rqa [$];
   rd_t          rqb [$];

   task automatic chk(input string nm, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                       input logic [N-1:0] l, input logic [N-1:0] eg,
                       input logic rv, input logic [DW-1:0] ed);
      int  k;
      wr_t we_e;
      rd_t re_e;
      k = 0;
      req = r; we = w; lock = l;
      for (int i = 0; i < N; i++) if (eg[i]) k = i;
      if (eg != '0) begin
         gq.push_back(eg);
         if (w[k]) begin
            we_e.due = cyc + 1; we_e.a = addr[k]; we_e.d = wd[k];
            wq.push_back(we_e);
         end else if (rv) begin
            re_e.due = cyc + 2; re_e.tag = eg; re_e.d = ed;
            rqa.push_back(re_e);
            re_e.due = cyc + 4;
            rqb.push_back(re_e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, '0, '0, 1'b0, '0);
   endtask

   logic [N-1:0] g;
   wr_t          wm;
   rd_t          ra, rb;

   always @(negedge clk) begin
      if (rst_n) begin
         if (|ifa.cl_gnt || |ifb.cl_gnt) begin
            if (gq.size() == 0)
               chk("gnt_unexp", DW'(ifa.cl_gnt | ifb.cl_gnt), '0);
            else begin
               g = gq.pop_front();
               chk("gnt_a", DW'(ifa.cl_gnt), DW'(g));
               chk("gnt_b", DW'(ifb.cl_gnt), DW'(g));
            end
         end
         if (mwe_a || mwe_b) begin
            if (wq.size() == 0)
               chk("we_unexp", DW'({mwe_a, mwe_b}), '0);
            else begin
               wm = wq.pop_front();
               chk("wr_we", DW'({mwe_a, mwe_b}), DW'(2'b11));
               chk("wr_cyc", DW'(cyc), DW'(wm.due));
               chk("wr_addr_a", DW'(maddr_a), DW'(wm.a));
               chk("wr_addr_b", DW'(maddr_b), DW'(wm.a));
               chk("wr_data_a", mwd_a, wm.d);
               chk("wr_data_b", mwd_b, wm.d);
            end
         end
         if (|ifa.cl_rvalid) begin
            if (rqa.size() == 0)
               chk("rv_unexp_a", DW'(ifa.cl_rvalid), '0);
            else begin
               ra = rqa.pop_front();
               chk("rv_tag_a", DW'(ifa.cl_rvalid), DW'(ra.tag));
               chk("rv_cyc_a", DW'(cyc), DW'(ra.due));
               chk("rv_data_a", ifa.cl_rdata, ra.d);
            end
         end
         if (|ifb.cl_rvalid) begin
            if (rqb.size() == 0)
               chk("rv_unexp_b", DW'(ifb.cl_rvalid), '0);
            else begin
               rb = rqb.pop_front();
               chk("rv_tag_b", DW'(ifb.cl_rvalid), DW'(rb.tag));
               chk("rv_cyc_b", DW'(cyc), DW'(rb.due));
               chk("rv_data_b", ifb.cl_rdata, rb.d);
            end
         end
      end
   end

   initial begin
      req = '1; we = '1; lock = '0;
      for (int i = 0; i < N; i++) begin
         addr[i] = AW'(16 + i);
         wd[i]   = {80{8'(16 + i)}};
      end

      // Reset held with every client requesting.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt_a", DW'(ifa.cl_gnt), '0);
      chk("rst_gnt_b", DW'(ifb.cl_gnt), '0);
      chk("rst_we", DW'({mwe_a, mwe_b}), '0);
      chk("rst_rv", DW'({ifa.cl_rvalid, ifb.cl_rvalid}), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fairness: all clients write continuously.
      for (int i = 0; i < 2; i++) begin
         step(3'b111, 3'b111, 3'b000, 3'b001, 1'b0, '0);
         step(3'b111, 3'b111, 3'b000, 3'b010, 1'b0, '0);
         step(3'b111, 3'b111, 3'b000, 3'b100, 1'b0, '0);
      end

      // Write then read-back of the same line.
      addr[0] = 9'h05;
      wd[0]   = {80{8'hA5}};
      step(3'b001, 3'b001, 3'b000, 3'b001, 1'b0, '0);
      addr[1] = 9'h05;
      step(3'b010, 3'b000, 3'b000, 3'b010, 1'b1, {80{8'hA5}});
      idle(5);

      // Back-to-back interleaved reads, pointer starts at 2.
      addr[0] = 9'h10;
      addr[1] = 9'h11;
      for (int i = 0; i < 2; i++) begin
         step(3'b011, 3'b000, 3'b000, 3'b001, 1'b1, {80{8'h10}});
         step(3'b011, 3'b000, 3'b000, 3'b010, 1'b1, {80{8'h11}});
      end
      idle(6);

      // Client 1 bursts 4 writes, lock on the first 3.
      addr[0] = 9'h30;
      wd[0]   = {80{8'hC3}};
      addr[1] = 9'h20;
      wd[1]   = {80{8'h5A}};
`ifdef VRAM_ARB_LOCK_EN
      step(3'b010, 3'b011, 3'b010, 3'b010, 1'b0, '0);
      addr[1] = 9'h21;
      step(3'b011, 3'b011, 3'b010, 3'b010, 1'b0, '0);
      addr[1] = 9'h22;
      step(3'b011, 3'b011, 3'b010, 3'b010, 1'b0, '0);
      addr[1] = 9'h23;
      step(3'b011, 3'b011, 3'b000, 3'b010, 1'b0, '0);
      step(3'b001, 3'b011, 3'b000, 3'b001, 1'b0, '0);
`else
      step(3'b010, 3'b011, 3'b010, 3'b010, 1'b0, '0);
      addr[1] = 9'h21;
      step(3'b011, 3'b011, 3'b010, 3'b001, 1'b0, '0);
      step(3'b011, 3'b011, 3'b010, 3'b010, 1'b0, '0);
      addr[1] = 9'h22;
      step(3'b011, 3'b011, 3'b010, 3'b001, 1'b0, '0);
      step(3'b011, 3'b011, 3'b010, 3'b010, 1'b0, '0);
      addr[1] = 9'h23;
      step(3'b011, 3'b011, 3'b000, 3'b001, 1'b0, '0);
      step(3'b011, 3'b011, 3'b000, 3'b010, 1'b0, '0);
`endif
      addr[2] = 9'h23;
      step(3'b100, 3'b000, 3'b000, 3'b100, 1'b1, {80{8'h5A}});
      idle(6);

      // Reset the cycle after a read grant: no rvalid, pointer to 0.
      addr[1] = 9'h05;
      step(3'b010, 3'b000, 3'b000, 3'b010, 1'b0, '0);
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(6);
      addr[0] = 9'h40;
      step(3'b111, 3'b111, 3'b000, 3'b001, 1'b0, '0);
      idle(4);

      chk("gq_left", DW'(gq.size()), '0);
      chk("wq_left", DW'(wq.size()), '0);
      chk("rqa_left", DW'(rqa.size()), '0);
      chk("rqb_left", DW'(rqb.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Parametrised successor to the two-writer VRAM muxer. Arbitrates N clients (register view, pipeline view, future text/console writers) onto the single read/write port A of the dual-port line VRAM. Port B stays dedicated to VGA scan-out. Adds fair round-robin arbitration, a per-transaction valid/grant handshake, read-back with client-tagged return, and an optional bus lock for multi-line bursts.

## Interface
- NUM_CLIENTS, 2: number of requesting clients, 2..8
- DATA_W, 640: VRAM line width in bits
- ADDR_W, 9: VRAM line address width
- RD_LATENCY, 1: VRAM port-A read latency in cycles, 1..3
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cl_req  in  NUM_CLIENTS  per-client request, held until granted
- cl_we  in  NUM_CLIENTS  1 = write line, 0 = read line
- cl_lock  in  NUM_CLIENTS  keep ownership after this grant (VRAM_ARB_LOCK_EN only)
- cl_addr  in  NUM_CLIENTS*ADDR_W  client i at bits [i*ADDR_W +: ADDR_W]
- cl_wdata  in  NUM_CLIENTS*DATA_W  client i at bits [i*DATA_W +: DATA_W]
- cl_gnt  out  NUM_CLIENTS  one-hot; acceptance of the current request
- cl_rvalid  out  NUM_CLIENTS  one-hot; read data for that client is on cl_rdata
- cl_rdata  out  DATA_W  shared read-return bus
- mem_we  out  1  VRAM port-A write enable
- mem_addr  out  ADDR_W  VRAM port-A address
- mem_wdata  out  DATA_W  VRAM port-A write data
- mem_rdata  in  DATA_W  VRAM port-A read data

## Operation
- Handshake: a transfer occurs on a clock edge where cl_req[i] & cl_gnt[i]. The client holds req, we, addr and wdata stable until that edge, and may drop or change them on the following cycle.
- cl_gnt is combinational from cl_req, the priority pointer and the lock owner. At most one bit is set. It is 0 when no request is pending and 0 while rst_n is low.
- Round-robin: the pointer p selects the first requesting client searching p, p+1, …, wrapping from NUM_CLIENTS-1 to 0. After a grant to client k, p becomes (k+1) mod NUM_CLIENTS. With no grant, p is unchanged.
- One transaction can be accepted per cycle. A sole requester is granted every cycle.
- Issue: the accepted transaction is registered onto mem_we, mem_addr and mem_wdata on the grant edge.
  - mem_we is high for exactly one cycle per accepted write.
  - Reads drive mem_addr with mem_we = 0.
  - In idle cycles mem_we = 0, and addr/wdata hold their last values.
- Read return: a tag shift register of depth RD_LATENCY carries {valid, client id}.
  - cl_rvalid[k] asserts exactly one cycle for each accepted read by client k.
  - cl_rdata = mem_rdata, passed through combinationally.
- Ordering: transactions reach VRAM in accept order. A read accepted one or more cycles after a write to the same address returns the new data, independent of the BRAM read/write-first mode.
- Reset: asynchronous assert clears p to 0, mem_we, mem_addr, mem_wdata, the tag pipe, cl_rvalid and the lock owner. Reads in flight at reset are dropped with no rvalid. Writes already registered on mem_* are lost.

## Timing
- Grant edge t: mem_* valid during cycle t+1.
- Read: cl_rvalid during cycle t+1+RD_LATENCY, i.e. t+2 at default.
- Back-to-back reads from alternating clients give back-to-back rvalid pulses with the correct one-hot tags.
- No combinational path from mem_rdata to any control output.

## Configuration
- VRAM_ARB_LOCK_EN defined:
  - A client granted with cl_lock high becomes the lock owner.
  - While the owner keeps cl_req high, every grant goes to the owner and other clients wait.
  - Ownership releases on the first grant with cl_lock low, or on any cycle the owner's cl_req is low.
  - p then advances past the owner as normal.
- VRAM_ARB_LOCK_EN undefined: cl_lock is ignored, no owner register exists, and arbitration is pure round-robin.

## Structure
- Package vram_pkg holds:
  - default DATA_W/ADDR_W constants shared with the VRAM, VGA and writer blocks;
  - a client-index width constant, clog2(NUM_CLIENTS) with minimum 1;
  - the read-tag struct typedef {valid, id}.
- Sub-module rr_picker: combinational one-hot round-robin select from (req vector, pointer), parametrised by NUM_CLIENTS. It is reused by any future arbiter.

## Test plan
- Reset: hold rst_n low with all cl_req high → cl_gnt = 0, mem_we = 0, cl_rvalid = 0. Release → first grant goes to client 0.
- Fairness, NUM_CLIENTS = 3: all clients request writes continuously → grants 0,1,2,0,1,2. mem_addr follows each client's address one cycle later, with mem_we high every cycle.
- Read return: client 1 reads addr 0x05 after client 0 writes 0x05 with pattern A5…A5 → cl_rvalid = 3'b010 exactly at grant+2 (RD_LATENCY = 1) with cl_rdata = A5…A5.
- Latency sweep at RD_LATENCY = 3: interleaved reads from clients 0 and 1 → rvalid one-hot tags appear in accept order, each 4 cycles after its grant.
- Lock (VRAM_ARB_LOCK_EN): client 1 writes 4 lines with cl_lock high on the first 3 while client 0 requests → client 0 is granted only after the 4th write. Without the macro, the grants alternate.
- Reset mid-read: assert rst_n low the cycle after a read grant → no cl_rvalid appears, and p returns to 0.
